prio_encoder_q: RTL and testbench

//  Parametrised, registered successor to the 4-to-2 encoder. Pulsed request lines are

---
 rtl/prio_encoder_q.sv | 135 +++++++++++++
 tb/tb_prio_encoder_q.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_q.sv
// Registered priority encoder: pulsed requests are latched into a pending vector and
// handed out one index at a time over valid/ready, using fixed-priority or round-robin selection.
module prio_encoder_q #(
    parameter int WIDTH = 8,
    parameter bit RR    = 1'b0,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W:0]   pend_cnt,
    output logic             overflow
);

    logic [WIDTH-1:0] r_pending;
    logic [IDX_W-1:0] r_ptr;
    logic             r_overflow;

    logic             w_valid;
    logic [IDX_W-1:0] w_sel_idx;
    logic [WIDTH-1:0] w_onehot;
    logic             w_accept;
    logic [WIDTH-1:0] w_clr_vec;
    logic [WIDTH-1:0] w_pending_next;
    logic             w_ovf_hit;
    logic [IDX_W-1:0] w_ptr_next;

    // Highest set index wins.
    function automatic logic [IDX_W-1:0] sel_fixed(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Walk downward over search offsets so the smallest offset from ptr is the last write.
    function automatic logic [IDX_W-1:0] sel_rr(input logic [WIDTH-1:0] vec,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W:0]   pos;
        idx = '0;
        pos = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(WIDTH)) begin
                pos = pos - (IDX_W+1)'(WIDTH);
            end else begin
                pos = pos;
            end
            if (vec[pos[IDX_W-1:0]]) begin
                idx = pos[IDX_W-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] vec);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + (IDX_W+1)'(vec[i]);
        end
        return cnt;
    endfunction

    // Selection and next-state terms, all derived from registered state plus this cycle's inputs.
    always_comb begin
        w_valid        = |r_pending;
        w_sel_idx      = '0;
        w_onehot       = '0;
        w_ptr_next     = r_ptr;
        if (!w_valid) begin
            w_sel_idx = '0;
        end else if (RR) begin
            w_sel_idx = sel_rr(r_pending, r_ptr);
        end else begin
            w_sel_idx = sel_fixed(r_pending);
        end
        if (w_valid) begin
            w_onehot = WIDTH'(1) << w_sel_idx;
        end else begin
            w_onehot = '0;
        end
        w_accept       = w_valid & out_ready;
        w_clr_vec      = w_accept ? w_onehot : '0;
        w_pending_next = (r_pending & ~w_clr_vec) | req;
        w_ovf_hit      = |(req & r_pending & ~w_clr_vec);
        if (w_sel_idx == IDX_W'(WIDTH - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_sel_idx + IDX_W'(1);
        end
    end

    // State registers; clr flushes pending/overflow but deliberately leaves ptr alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_pending  <= '0;
            r_ptr      <= r_ptr;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= r_overflow | w_ovf_hit;
            if (RR && w_accept) begin
                r_ptr <= w_ptr_next;
            end else begin
                r_ptr <= r_ptr;
            end
        end
    end

    assign out_valid  = w_valid;
    assign out_idx    = w_sel_idx;
    assign out_onehot = w_onehot;
    assign pend_cnt   = popcount(r_pending);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Table-driven bench for prio_encoder_q: fixed (W=8), round-robin (W=8) and round-robin (W=5)
// instances, with expected outputs queued at drive time and compared one edge later.
module tb_prio_encoder_q;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       d0_rst_n, d0_clr, d0_rdy, d0_valid, d0_ovf;
    logic [7:0] d0_req, d0_oh;
    logic [2:0] d0_idx;
    logic [3:0] d0_cnt;
    logic       d1_rst_n, d1_clr, d1_rdy, d1_valid, d1_ovf;
    logic [7:0] d1_req, d1_oh;
    logic [2:0] d1_idx;
    logic [3:0] d1_cnt;
    logic       d2_rst_n, d2_clr, d2_rdy, d2_valid, d2_ovf;
    logic [4:0] d2_req, d2_oh;
    logic [2:0] d2_idx;
    logic [3:0] d2_cnt;

    prio_encoder_q #(.WIDTH(8), .RR(1'b0)) u_fix (
        .clk(clk), .rst_n(d0_rst_n), .req(d0_req), .clr(d0_clr), .out_ready(d0_rdy),
        .out_valid(d0_valid), .out_idx(d0_idx), .out_onehot(d0_oh), .pend_cnt(d0_cnt),
        .overflow(d0_ovf));

    prio_encoder_q #(.WIDTH(8), .RR(1'b1)) u_rr (
        .clk(clk), .rst_n(d1_rst_n), .req(d1_req), .clr(d1_clr), .out_ready(d1_rdy),
        .out_valid(d1_valid), .out_idx(d1_idx), .out_onehot(d1_oh), .pend_cnt(d1_cnt),
        .overflow(d1_ovf));

    prio_encoder_q #(.WIDTH(5), .RR(1'b1)) u_rr5 (
        .clk(clk), .rst_n(d2_rst_n), .req(d2_req), .clr(d2_clr), .out_ready(d2_rdy),
        .out_valid(d2_valid), .out_idx(d2_idx), .out_onehot(d2_oh), .pend_cnt(d2_cnt),
        .overflow(d2_ovf));

    typedef struct {
        int         dut;
        logic       rst;
        logic [7:0] req;
        logic       clr;
        logic       rdy;
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    function automatic vec_t mk(int dut, logic rst, logic [7:0] req, logic clr, logic rdy,
                                logic v, logic [2:0] idx, logic [7:0] oh, logic [3:0] cnt,
                                logic ovf);
        vec_t t;
        t.dut = dut; t.rst = rst; t.req = req; t.clr = clr; t.rdy = rdy;
        t.v = v; t.idx = idx; t.oh = oh; t.cnt = cnt; t.ovf = ovf;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, vec_no, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        logic       v, o;
        logic [2:0] i;
        logic [7:0] h;
        logic [3:0] c;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", vec_no);
        end else begin
            e = exp_q.pop_front();
            case (e.dut)
                0:       begin v = d0_valid; i = d0_idx; h = d0_oh; c = d0_cnt; o = d0_ovf; end
                1:       begin v = d1_valid; i = d1_idx; h = d1_oh; c = d1_cnt; o = d1_ovf; end
                default: begin v = d2_valid; i = d2_idx; h = {3'b000, d2_oh}; c = d2_cnt; o = d2_ovf; end
            endcase
            cmp("valid",    {7'd0, v}, {7'd0, e.v});
            cmp("idx",      {5'd0, i}, {5'd0, e.idx});
            cmp("onehot",   h,         e.oh);
            cmp("pend_cnt", {4'd0, c}, {4'd0, e.cnt});
            cmp("overflow", {7'd0, o}, {7'd0, e.ovf});
        end
        vec_no++;
    endtask

    task automatic step(input vec_t t);
        d0_rst_n = 1'b1; d0_req = 8'h00; d0_clr = 1'b0; d0_rdy = 1'b0;
        d1_rst_n = 1'b1; d1_req = 8'h00; d1_clr = 1'b0; d1_rdy = 1'b0;
        d2_rst_n = 1'b1; d2_req = 5'h00; d2_clr = 1'b0; d2_rdy = 1'b0;
        case (t.dut)
            0:       begin d0_rst_n = t.rst; d0_req = t.req; d0_clr = t.clr; d0_rdy = t.rdy; end
            1:       begin d1_rst_n = t.rst; d1_req = t.req; d1_clr = t.clr; d1_rdy = t.rdy; end
            default: begin d2_rst_n = t.rst; d2_req = t.req[4:0]; d2_clr = t.clr; d2_rdy = t.rdy; end
        endcase
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        // Reset every instance with all requests high.
        vecs.push_back(mk(0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(2, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(2, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Fixed: single-line sweep
        vecs.push_back(mk(0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Fixed: A5 drains 7,5,2,0
        vecs.push_back(mk(0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 4'd4, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 4'd3, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 4'd2, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Fixed: back-pressure, overflow, higher-priority arrival, clr
        vecs.push_back(mk(0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b1));
        vecs.push_back(mk(0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 4'd2, 1'b1));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Fixed: overflow is sticky through a drain
        vecs.push_back(mk(0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 4'd1, 1'b1));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b1));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Fixed: retire and re-request on the same line in one cycle
        vecs.push_back(mk(0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 4'd1, 1'b0));
        vecs.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Round-robin W=8: A5 drains 0,2,5,7, then 81 drains 0,7
        vecs.push_back(mk(1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 4'd4, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 4'd3, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 4'd2, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 4'd1, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 4'd2, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 4'd1, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Round-robin W=8: search from ptr=7 wraps, earlier-in-search arrival preempts
        vecs.push_back(mk(1, 1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 4'd1, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 4'd2, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 4'd3, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 4'd2, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 4'd1, 1'b0));
        vecs.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        // Round-robin W=5: top index accepted, ptr wraps to 0
        vecs.push_back(mk(2, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 4'd1, 1'b0));
        vecs.push_back(mk(2, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 4'd2, 1'b0));
        vecs.push_back(mk(2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 4'd1, 1'b0));
        vecs.push_back(mk(2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));

        for (int n = 0; n < vecs.size(); n++) begin
            step(vecs[n]);
        end

        // Reset asserted mid-drain clears everything on the next edge.
        step(mk(0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 4'd4, 1'b0));
        step(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 4'd3, 1'b0));
        step(mk(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));
        step(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));

        // Reset beats a simultaneous clr and request on the round-robin instance.
        step(mk(1, 1'b1, 8'h18, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 4'd2, 1'b0));
        step(mk(1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
